// File: rtl/mac_pkg.sv
// Shared constants and lookup helpers for the output-buffer requant drain path.
package mac_pkg;

  localparam int IN_W    = 128;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;

  localparam logic [1:0] MODE_2B  = 2'b00;
  localparam logic [1:0] MODE_4B  = 2'b01;
  localparam logic [1:0] MODE_8B  = 2'b10;
  localparam logic [1:0] MODE_BAD = 2'b11;

  localparam int OUT_MIN = -128;
  localparam int OUT_MAX = 127;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  function automatic logic [4:0] lane_count(input logic [1:0] mode);
    case (mode)
      MODE_2B: return 5'd16;
      MODE_4B: return 5'd4;
      default: return 5'd1;
    endcase
  endfunction

  function automatic logic [4:0] lane_width(input logic [1:0] mode);
    case (mode)
      MODE_2B: return 5'd8;
      MODE_4B: return 5'd12;
      default: return 5'd20;
    endcase
  endfunction

endpackage

// File: rtl/lane_requant.sv
// Combinational per-lane requantizer: rounding arithmetic right shift, then
// saturation to signed 8 bit. Macro RELU_EN clamps negative results to zero.
module lane_requant
  import mac_pkg::*;
(
  input  logic signed [20:0]        lane,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [OUT_W-1:0]   result
);

  logic        [21:0] rnd;
  logic signed [21:0] sum;
  logic signed [21:0] shifted;

  always_comb begin
    rnd = '0;
    if (shift != '0) rnd = 22'd1 << (shift - SHIFT_W'(1));
    // one guard bit keeps the half-LSB rounding add from overflowing
    sum     = {lane[20], lane} + rnd;
    shifted = sum >>> shift;
    if (shifted > 22'(OUT_MAX))
      result = OUT_W'(OUT_MAX);
    else if (shifted < 22'(OUT_MIN))
      result = OUT_W'(OUT_MIN);
    else
      result = shifted[OUT_W-1:0];
`ifdef RELU_EN
    if (result[OUT_W-1]) result = '0;
`endif
  end

endmodule

// File: rtl/obuf_requant_drain.sv
// Unpacks one packed accumulator word per batch and streams requantized lanes
// out one per cycle. Optional macro RELU_EN (in lane_requant) zeroes negatives.
//
//   state    | meaning
//   ST_IDLE  | no word held; in_ready=1, out_valid=0
//   ST_DRAIN | presenting lanes of the captured word; out_valid=1
module obuf_requant_drain
  import mac_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  input  logic [1:0]         in_mode,
  input  logic [SHIFT_W-1:0] in_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [3:0]         out_lane,
  output logic               out_last,
  output logic               err_mode
);

  drain_state_e state;

  logic [IN_W-1:0]    cap_data;
  logic [1:0]         cap_mode;
  logic [SHIFT_W-1:0] cap_shift;

  logic               take;
  logic               adv;
  logic [IN_W-1:0]    src_data;
  logic [1:0]         src_mode;
  logic [SHIFT_W-1:0] src_shift;
  logic [3:0]         src_lane;
  logic               src_last;
  logic [7:0]         b8;
  logic [11:0]        b12;
  logic signed [20:0] lane_ext;
  logic signed [20:0] rq_lane;
  logic [SHIFT_W-1:0] rq_shift;
  logic signed [OUT_W-1:0] rq_out;

  assign in_ready = (state == ST_IDLE) || (out_ready && out_last);
  assign take     = in_valid && in_ready;
  assign adv      = out_valid && out_ready;

  // The lane computed here is the one that will be presented after the next
  // edge: lane 0 of the incoming word on capture, else the following lane.
  always_comb begin
    src_data  = take ? in_data  : cap_data;
    src_mode  = take ? in_mode  : cap_mode;
    src_shift = take ? in_shift : cap_shift;
    src_lane  = take ? 4'd0 : out_lane + 4'd1;

    b8  = '0;
    b12 = '0;
    for (int i = 0; i < 16; i++)
      if (src_lane == 4'(i)) b8 = src_data[8*i +: 8];
    for (int i = 0; i < 4; i++)
      if (src_lane[1:0] == 2'(i)) b12 = src_data[12*i +: 12];

    case (src_mode)
      MODE_4B: lane_ext = {{9{b12[11]}}, b12};
      MODE_8B: lane_ext = {src_data[19], src_data[19:0]};
      default: lane_ext = {{13{b8[7]}}, b8};
    endcase

    // Shifting out every magnitude bit leaves only the sign.
    if (src_shift >= lane_width(src_mode)) begin
      rq_lane  = {21{lane_ext[20]}};
      rq_shift = '0;
    end else begin
      rq_lane  = lane_ext;
      rq_shift = src_shift;
    end

    src_last = ({1'b0, src_lane} == lane_count(src_mode) - 5'd1);
  end

  lane_requant u_lane_requant (
    .lane   (rq_lane),
    .shift  (rq_shift),
    .result (rq_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cap_data  <= '0;
      cap_mode  <= '0;
      cap_shift <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= '0;
      out_last  <= 1'b0;
      err_mode  <= 1'b0;
    end else begin
      err_mode <= 1'b0;
      if (take) begin
        cap_data  <= in_data;
        cap_mode  <= in_mode;
        cap_shift <= in_shift;
        if (in_mode == MODE_BAD) begin
          state     <= ST_IDLE;
          err_mode  <= 1'b1;
          out_valid <= 1'b0;
          out_lane  <= '0;
          out_last  <= 1'b0;
        end else begin
          state     <= ST_DRAIN;
          out_valid <= 1'b1;
          out_data  <= rq_out;
          out_lane  <= '0;
          out_last  <= src_last;
        end
      end else if (adv) begin
        if (out_last) begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_lane  <= '0;
          out_last  <= 1'b0;
        end else begin
          out_data <= rq_out;
          out_lane <= src_lane;
          out_last <= src_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_obuf_requant_drain.sv
// Self-checking bench for obuf_requant_drain: lane-level reference model plus
// directed vectors with hand-computed literals. Honours RELU_EN when defined.
module tb_obuf_requant_drain;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [1:0]   in_mode = '0;
  logic [4:0]   in_shift = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [7:0]   out_data;
  logic [3:0]   out_lane;
  logic         out_last;
  logic         err_mode;

  obuf_requant_drain dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_shift  (in_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .err_mode  (err_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int lane;
    int last;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  int   got_data[$];
  int   got_lane[$];
  int   got_last[$];
  bit   err_pend = 1'b0;
  bit   rnd_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int requant(input int r, input int s, input int w);
    int v;
    if (s >= w) v = (r < 0) ? -1 : 0;
    else if (s > 0) v = (r + (1 << (s - 1))) >>> s;
    else v = r;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`ifdef RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  function automatic void push_word(input logic [127:0] d, input logic [1:0] m, input int s);
    int n, w;
    n = (m == 2'b00) ? 16 : (m == 2'b01) ? 4 : 1;
    w = (m == 2'b00) ? 8 : (m == 2'b01) ? 12 : 20;
    for (int i = 0; i < n; i++) begin
      logic [127:0] t;
      int r;
      exp_t e;
      t = d >> (w * i);
      r = 0;
      for (int b = 0; b < w; b++) r[b] = t[b];
      if (t[w-1]) r = r - (1 << w);
      e.data = requant(r, s, w);
      e.lane = i;
      e.last = (i == n - 1) ? 1 : 0;
      q.push_back(e);
    end
  endfunction

  // Compare process: every cycle, outputs against the model queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        err_pend = 1'b0;
      end else begin
        chk("in_ready", int'(in_ready), int'(q.size() == 0 || (out_ready && q.size() == 1)));
        chk("out_valid", int'(out_valid), int'(q.size() != 0));
        if (out_valid && q.size() != 0) begin
          chk("out_data", int'($signed(out_data)), q[0].data);
          chk("out_lane", int'(out_lane), q[0].lane);
          chk("out_last", int'(out_last), q[0].last);
          if (out_ready) begin
            got_data.push_back(int'($signed(out_data)));
            got_lane.push_back(int'(out_lane));
            got_last.push_back(int'(out_last));
            void'(q.pop_front());
          end
        end
        chk("err_mode", int'(err_mode), int'(err_pend));
        err_pend = in_valid && in_ready && (in_mode == 2'b11);
        if (in_valid && in_ready && in_mode != 2'b11)
          push_word(in_data, in_mode, int'(in_shift));
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic [1:0] m, input logic [4:0] s);
    int n;
    in_data  = d;
    in_mode  = m;
    in_shift = s;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 after %0d cycles", n);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0 || out_valid) begin
      failures++;
      $display("FAIL drain_timeout: pending lanes got %0d expected 0", q.size());
    end
  endtask

  task automatic wait_lane(input int lane);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(out_valid && int'(out_lane) == lane) && n < 100);
    chk("wait_lane", int'(out_lane), lane);
  endtask

  task automatic clear_log();
    got_data.delete();
    got_lane.delete();
    got_last.delete();
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time got 500000 expected less");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int e4[4];
    logic [127:0] w;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_lane", int'(out_lane), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_err_mode", int'(err_mode), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // 8b mode: 768 >> 2 with rounding = 192, saturates to 127
    clear_log();
    send({108'd0, 20'h00300}, 2'b10, 5'd2);
    wait_drain();
    chk("m8_count", got_data.size(), 1);
    chk("m8_data", got_data.size() > 0 ? got_data[0] : -999, 127);
    chk("m8_last", got_last.size() > 0 ? got_last[0] : -999, 1);

    // 4b mode: -10, 10, 2047, -2048 with shift 1
    clear_log();
    send({80'd0, 12'h800, 12'h7FF, 12'h00A, 12'hFF6}, 2'b01, 5'd1);
    wait_drain();
`ifdef RELU_EN
    e4 = '{0, 5, 127, 0};
`else
    e4 = '{-5, 5, 127, -128};
`endif
    chk("m4_count", got_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("m4_data", i < got_data.size() ? got_data[i] : -999, e4[i]);
      chk("m4_lane", i < got_lane.size() ? got_lane[i] : -999, i);
      chk("m4_last", i < got_last.size() ? got_last[i] : -999, (i == 3) ? 1 : 0);
    end

    // 2b mode: all lanes 3, shift 1 -> 2; stall 5 cycles on lane 7
    clear_log();
    send({16{8'h03}}, 2'b00, 5'd1);
    wait_lane(7);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_lane", int'(out_lane), 7);
      chk("stall_data", int'($signed(out_data)), 2);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();
    chk("m2_count", got_data.size(), 16);
    for (int i = 0; i < got_data.size(); i++) begin
      chk("m2_data", got_data[i], 2);
      chk("m2_lane", got_lane[i], i);
    end

    // Back-to-back: 8b word accepted on the 4b word's final handshake
    clear_log();
    send({80'd0, 12'd4, 12'd3, 12'd2, 12'd1}, 2'b01, 5'd0);
    send({108'd0, 20'h00040}, 2'b10, 5'd0);
    chk("b2b_valid", int'(out_valid), 1);
    chk("b2b_lane", int'(out_lane), 0);
    chk("b2b_data", int'($signed(out_data)), 64);
    chk("b2b_last", int'(out_last), 1);
    wait_drain();
    chk("b2b_count", got_data.size(), 5);
    chk("b2b_lane3", got_data.size() > 3 ? got_data[3] : -999, 4);

    // Illegal mode dropped with a one-cycle error pulse
    clear_log();
    send({4{32'hDEADBEEF}}, 2'b11, 5'd3);
    chk("err_pulse", int'(err_mode), 1);
    chk("err_no_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("err_clear", int'(err_mode), 0);
    chk("err_no_valid2", int'(out_valid), 0);
    // -128 >> 3 with rounding: (-124) >>> 3 = -16
    send({108'd0, 20'hFFF80}, 2'b10, 5'd3);
    wait_drain();
    chk("post_err_count", got_data.size(), 1);
`ifdef RELU_EN
    chk("post_err_data", got_data.size() > 0 ? got_data[0] : -999, 0);
`else
    chk("post_err_data", got_data.size() > 0 ? got_data[0] : -999, -16);
`endif

    // Async reset in the middle of a 2b drain
    for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(i * 7);
    send(w, 2'b00, 5'd0);
    wait_lane(5);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_lane", int'(out_lane), 0);
    chk("mid_rst_last", int'(out_last), 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_valid", int'(out_valid), 0);
      chk("post_rst_ready", int'(in_ready), 1);
    end
    @(posedge clk);
    #1;

    // Mixed words with random backpressure, including shifts past lane width
    fork
      begin
        send({16{8'h85}}, 2'b00, 5'd9);
        send({16{8'h7A}}, 2'b00, 5'd8);
        send({108'd0, 20'h80000}, 2'b10, 5'd20);
        for (int k = 0; k < 12; k++)
          send({$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 2)),
               5'($urandom_range(0, 12)));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    summary();
    $finish;
  end

endmodule
